// File: rtl/sram_arbiter_if.sv
// Request/response bundle between two CPU-side masters, the arbiter and one single-port SRAM.
// The arbiter uses the slave modport; the CPU/SRAM side of the bundle uses the master modport.
interface sram_arbiter_if #(
  parameter int ADDR  = 8,
  parameter int WIDTH = 32
);
  logic             m0_valid;
  logic             m0_we;
  logic [ADDR-1:0]  m0_addr;
  logic [WIDTH-1:0] m0_wdata;
  logic             m0_ready;
  logic             m0_rvalid;
  logic [WIDTH-1:0] m0_rdata;

  logic             m1_valid;
  logic             m1_we;
  logic [ADDR-1:0]  m1_addr;
  logic [WIDTH-1:0] m1_wdata;
  logic             m1_ready;
  logic             m1_rvalid;
  logic [WIDTH-1:0] m1_rdata;

  logic             mem_we;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output m0_valid, m0_we, m0_addr, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_valid, m0_we, m0_addr, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a single-port SRAM with a 1-cycle registered read.
// Burst-limited round-robin: a master keeps the port for at most MAX_BURST cycles under contention.
module sram_arbiter #(
  parameter int ADDR      = 8,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           res,
  sram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ADDR-1:0]  addr_hold_q, addr_hold_d;
  logic [WIDTH-1:0] wdata_hold_q, wdata_hold_d;
  logic             rsel_q, rsel_d;
  logic             rpend_q, rpend_d;

  logic             gnt_any;
  logic             gnt_sel;
  logic             keep_last;
  logic             sel_we;
  logic [ADDR-1:0]  sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= MAX_CNT) return MAX_CNT;
    return cnt + ONE_CNT;
  endfunction

  // The last winner keeps the port only while its burst is open and below the limit.
  assign keep_last = (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (res) begin
      unique case ({bus.m1_valid, bus.m0_valid})
        2'b01: begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end
        2'b10: begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
        2'b11: begin
          gnt_any = 1'b1;
          gnt_sel = keep_last ? rr_last_q : ~rr_last_q;
        end
        default: begin
          gnt_any = 1'b0;
          gnt_sel = 1'b0;
        end
      endcase
    end
  end

  assign sel_we    = gnt_sel ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = gnt_sel ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = gnt_sel ? bus.m1_wdata : bus.m0_wdata;

  assign bus.m0_ready = gnt_any & ~gnt_sel;
  assign bus.m1_ready = gnt_any &  gnt_sel;

  // When idle the SRAM keeps re-reading the last address with no write.
  assign bus.mem_we    = gnt_any & sel_we;
  assign bus.mem_addr  = gnt_any ? sel_addr  : addr_hold_q;
  assign bus.mem_wdata = gnt_any ? sel_wdata : wdata_hold_q;

  // Responses are masked while reset is held so an in-flight read never completes.
  assign bus.m0_rvalid = res & rpend_q & ~rsel_q;
  assign bus.m1_rvalid = res & rpend_q &  rsel_q;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;

  always_comb begin
    rr_last_d    = rr_last_q;
    burst_cnt_d  = burst_cnt_q;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    rsel_d       = rsel_q;
    rpend_d      = 1'b0;
    if (gnt_any) begin
      rr_last_d    = gnt_sel;
      addr_hold_d  = sel_addr;
      wdata_hold_d = sel_wdata;
      rsel_d       = gnt_sel;
      rpend_d      = ~sel_we;
      if ((gnt_sel == rr_last_q) && (burst_cnt_q != '0)) begin
        burst_cnt_d = sat_inc(burst_cnt_q);
      end else begin
        burst_cnt_d = ONE_CNT;
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // rr_last resets to m1 so the first contention after reset goes to m0.
  always_ff @(posedge clk) begin
    if (!res) begin
      rr_last_q    <= 1'b1;
      burst_cnt_q  <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rsel_q       <= 1'b0;
      rpend_q      <= 1'b0;
    end else begin
      rr_last_q    <= rr_last_d;
      burst_cnt_q  <= burst_cnt_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
      rsel_q       <= rsel_d;
      rpend_q      <= rpend_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, read-data scoreboard and per-scenario directed tasks.
module tb_sram_arbiter;
  localparam int ADDR      = 8;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

  sram_arbiter #(.ADDR(ADDR), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  logic [WIDTH-1:0] sram    [0:(1<<ADDR)-1];
  logic [WIDTH-1:0] ref_mem [0:(1<<ADDR)-1];
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];

  always @(posedge clk) begin
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= sram[bus.mem_addr];
  end

  // Scoreboard: reads push the reference value at issue, responses pop and compare.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    if (!res) begin
      q0.delete();
      q1.delete();
    end else begin
      if (bus.m0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb_m0_unexpected_rvalid: got rvalid=1 rdata=%h, required no response", bus.m0_rdata);
        end else begin
          exp_d = q0.pop_front();
          if (bus.m0_rdata !== exp_d) begin
            errors++;
            $display("FAIL sb_m0_rdata: got %h, required %h", bus.m0_rdata, exp_d);
          end
        end
      end
      if (bus.m1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb_m1_unexpected_rvalid: got rvalid=1 rdata=%h, required no response", bus.m1_rdata);
        end else begin
          exp_d = q1.pop_front();
          if (bus.m1_rdata !== exp_d) begin
            errors++;
            $display("FAIL sb_m1_rdata: got %h, required %h", bus.m1_rdata, exp_d);
          end
        end
      end
      if (bus.m0_valid && bus.m0_ready) begin
        if (bus.m0_we) ref_mem[bus.m0_addr] = bus.m0_wdata;
        else q0.push_back(ref_mem[bus.m0_addr]);
      end
      if (bus.m1_valid && bus.m1_ready) begin
        if (bus.m1_we) ref_mem[bus.m1_addr] = bus.m1_wdata;
        else q1.push_back(ref_mem[bus.m1_addr]);
      end
      if (q0.size() > 1 || q1.size() > 1) begin
        checks++;
        errors++;
        $display("FAIL sb_latency: outstanding reads m0=%0d m1=%0d, required at most 1", q0.size(), q1.size());
        q0.delete();
        q1.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_valid = 1'b0;
    bus.m1_valid = 1'b0;
    bus.m0_we    = 1'b0;
    bus.m1_we    = 1'b0;
  endtask

  task automatic test_reset();
    res          = 1'b0;
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 8'h55;
    bus.m0_wdata = 32'hFFFF_FFFF;
    bus.m1_valid = 1'b1;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = 8'hAA;
    bus.m1_wdata = 32'h1234_5678;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b0) begin errors++; $display("FAIL rst_m0_ready: got %b, required 0", bus.m0_ready); end
    checks++; if (bus.m1_ready !== 1'b0) begin errors++; $display("FAIL rst_m1_ready: got %b, required 0", bus.m1_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b, required 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h, required 00", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h, required 0", bus.mem_wdata); end
    checks++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b, required 00", bus.m0_rvalid, bus.m1_rvalid); end
    tick();
    idle_inputs();
    res = 1'b1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) begin
      bus.m0_valid = 1'b1;
      bus.m0_we    = 1'b1;
      bus.m0_addr  = 8'(i);
      bus.m0_wdata = 32'hC0DE_0000 + 32'(i * 17);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 8'h10;
    bus.m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b1) begin errors++; $display("FAIL wr_m0_ready: got %b, required 1", bus.m0_ready); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_mem_bus: got we=%b addr=%h data=%h, required we=1 addr=10 data=deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.m0_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_issue: got ready=%b we=%b, required ready=1 we=0", bus.m0_ready, bus.mem_we); end
    checks++; if (bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid_a: got %b, required 0", bus.m1_rvalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_return: got rvalid=%b rdata=%h, required rvalid=1 rdata=deadbeef", bus.m0_rvalid, bus.m0_rdata);
    end
    checks++; if (bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid_b: got %b, required 0", bus.m1_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b, required 0", bus.m0_rvalid); end
    tick();
  endtask

  task automatic test_round_robin();
    int seq [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    res = 1'b0;
    idle_inputs();
    tick();
    res = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.m0_valid = 1'b1;
      bus.m0_we    = 1'b0;
      bus.m0_addr  = 8'(i % 16);
      bus.m1_valid = 1'b1;
      bus.m1_we    = 1'b0;
      bus.m1_addr  = 8'(15 - (i % 16));
      @(negedge clk);
      checks++;
      if (bus.m0_ready !== (seq[i] == 0) || bus.m1_ready !== (seq[i] == 1)) begin
        errors++; $display("FAIL rr_grant[%0d]: got ready m0=%b m1=%b, required master %0d", i, bus.m0_ready, bus.m1_ready, seq[i]);
      end
      if (i > 0) begin
        checks++;
        if (bus.m0_rvalid !== (seq[i-1] == 0) || bus.m1_rvalid !== (seq[i-1] == 1)) begin
          errors++; $display("FAIL rr_rvalid[%0d]: got m0=%b m1=%b, required master %0d", i, bus.m0_rvalid, bus.m1_rvalid, seq[i-1]);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    bus.m1_valid = 1'b1;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = 8'h05;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0) begin
        errors++; $display("FAIL alone_m1[%0d]: got ready m0=%b m1=%b, required m1", i, bus.m0_ready, bus.m1_ready);
      end
      tick();
    end
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b0;
    bus.m0_addr  = 8'h06;
    @(negedge clk);
    checks++;
    if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0) begin
      errors++; $display("FAIL starve_m0: got ready m0=%b m1=%b, required m0", bus.m0_ready, bus.m1_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_same_cycle();
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 8'h30;
    bus.m0_wdata = 32'h1;
    tick();
    bus.m0_we    = 1'b0;
    bus.m1_valid = 1'b1;
    bus.m1_we    = 1'b1;
    bus.m1_addr  = 8'h30;
    bus.m1_wdata = 32'h2;
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL same_first: got ready m0=%b m1=%b, required m0", bus.m0_ready, bus.m1_ready); end
    tick();
    bus.m0_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.m1_ready !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL same_m1_write: got ready=%b we=%b, required 1 1", bus.m1_ready, bus.mem_we); end
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h1) begin errors++; $display("FAIL same_old_data: got rvalid=%b rdata=%h, required 1 00000001", bus.m0_rvalid, bus.m0_rdata); end
    tick();
    bus.m1_valid = 1'b0;
    bus.m1_we    = 1'b0;
    bus.m0_valid = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h2) begin errors++; $display("FAIL same_new_data: got rvalid=%b rdata=%h, required 1 00000002", bus.m0_rvalid, bus.m0_rdata); end
    tick();
  endtask

  task automatic test_idle_hold();
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 8'h20;
    bus.m0_wdata = 32'h1234_5678;
    tick();
    bus.m0_we = 1'b0;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 8'h20 || bus.mem_we !== 1'b0) begin
        errors++; $display("FAIL idle_hold[%0d]: got addr=%h we=%b, required addr=20 we=0", i, bus.mem_addr, bus.mem_we);
      end
      tick();
    end
    bus.m0_valid = 1'b1;
    bus.m0_addr  = 8'h20;
    bus.m1_valid = 1'b1;
    bus.m1_addr  = 8'h10;
    @(negedge clk);
    checks++;
    if (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0) begin
      errors++; $display("FAIL gap_priority: got ready m0=%b m1=%b, required m1", bus.m0_ready, bus.m1_ready);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    bus.m0_valid = 1'b1;
    bus.m0_we    = 1'b0;
    bus.m0_addr  = 8'h10;
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b1) begin errors++; $display("FAIL inflight_issue: got %b, required 1", bus.m0_ready); end
    tick();
    res          = 1'b0;
    bus.m1_valid = 1'b1;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = 8'h05;
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_rvalid: got %b%b, required 00", bus.m0_rvalid, bus.m1_rvalid); end
    checks++; if (bus.m0_ready !== 1'b0 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL inflight_ready: got %b%b, required 00", bus.m0_ready, bus.m1_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL inflight_mem_we: got %b, required 0", bus.mem_we); end
    tick();
    res = 1'b1;
    @(negedge clk);
    checks++; if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL post_reset_grant: got ready m0=%b m1=%b, required m0", bus.m0_ready, bus.m1_ready); end
    checks++; if (bus.m0_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b, required 0", bus.m0_rvalid); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    res          = 1'b0;
    bus.m0_valid = 1'b0;
    bus.m0_we    = 1'b0;
    bus.m0_addr  = '0;
    bus.m0_wdata = '0;
    bus.m1_valid = 1'b0;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = '0;
    bus.m1_wdata = '0;

    test_reset();
    init_mem();
    test_write_read();
    test_round_robin();
    test_starvation();
    test_same_cycle();
    test_idle_hold();
    test_reset_inflight();

    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL drain: outstanding reads m0=%0d m1=%0d, required 0 0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
